// File: rtl/reset_sequencer_pkg.sv
// Shared constants for the peripheral reset sequencer: state encoding,
// CSR register offsets, counter width and the STATUS byte layout.
package reset_sequencer_pkg;

  localparam int CNT_W = 8;
  localparam int IDX_W = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_STEP  = 2'd2;
  localparam logic [1:0] ST_PULSE = 2'd3;

  localparam logic [4:0] CTRL_OFS   = 5'd0;
  localparam logic [4:0] STATUS_OFS = 5'd1;

  // STATUS layout: {busy, 0, state[1:0], 0, idx[2:0]}
  function automatic logic [7:0] status_byte(input logic busy,
                                             input logic [1:0] st,
                                             input logic [IDX_W-1:0] idx);
    return {busy, 1'b0, st, 1'b0, idx};
  endfunction

endpackage

// File: rtl/reset_sequencer_ce_down_counter.sv
// Tick-enabled down counter shared by the HOLD, STEP and PULSE phases.
// A load wins over a decrement; the count parks at zero.
module ce_down_counter
  import reset_sequencer_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (ce && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Holds all peripheral resets after power-on, releases them one by one at a
// programmable tick spacing, and lets software re-pulse single resets over CSR.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter logic [4:0]       BASE_ADDR  = 5'h0,
  parameter int               NUM_OUTS   = 6,
  parameter logic [CNT_W-1:0] HOLD_TICKS = 8'd32,
  parameter logic [CNT_W-1:0] STEP_TICKS = 8'd16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                start,
  input  logic [NUM_OUTS-1:0] hold_mask,
  input  logic [4:0]          csr_a,
  input  logic [7:0]          csr_di,
  input  logic                csr_we,
  output logic [7:0]          csr_do,
  output logic [NUM_OUTS-1:0] rst_out,
  output logic                busy,
  output logic                done
);

  logic [1:0]          state;
  logic [NUM_OUTS-1:0] rst_q;
  logic [NUM_OUTS-1:0] pending;
  logic [NUM_OUTS-1:0] pulse_set;
  logic [NUM_OUTS-1:0] rel_mask;
  logic [NUM_OUTS-1:0] wr_bits;
  logic [IDX_W-1:0]    idx;

  logic             ctrl_sel;
  logic             status_sel;
  logic             ctrl_wr;
  logic             svc_pulse;
  logic             seq_state;
  logic             tick;
  logic             is_last;
  logic             cnt_zero;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             unused_csr_di;

  assign ctrl_sel   = (csr_a == BASE_ADDR + CTRL_OFS);
  assign status_sel = (csr_a == BASE_ADDR + STATUS_OFS);
  assign ctrl_wr    = csr_we && ctrl_sel;
  assign wr_bits    = ctrl_wr ? csr_di[NUM_OUTS-1:0] : '0;

  assign seq_state = (state == ST_HOLD) || (state == ST_STEP);
  assign svc_pulse = (state == ST_IDLE) && (pending != '0) && !start;
  assign tick      = ce && cnt_zero;
  assign is_last   = (idx == IDX_W'(NUM_OUTS - 1));

  // One-hot select of the output released at the current step
  always_comb begin
    rel_mask = '0;
    for (int i = 0; i < NUM_OUTS; i++) begin
      rel_mask[i] = (idx == IDX_W'(i));
    end
  end

  assign cnt_load     = start || svc_pulse || (seq_state && tick);
  assign cnt_load_val = (start || svc_pulse) ? HOLD_TICKS : STEP_TICKS;

  ce_down_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rst_q     <= '1;
      pending   <= '0;
      pulse_set <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done    <= 1'b0;
      pending <= pending | wr_bits;
      if (start) begin
        // A start always restarts from scratch; queued pulses stay queued
        state <= ST_HOLD;
        rst_q <= '1;
        idx   <= '0;
        busy  <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (pending != '0) begin
              state     <= ST_PULSE;
              busy      <= 1'b1;
              pulse_set <= pending;
              pending   <= wr_bits;
              rst_q     <= rst_q | pending;
            end
          end
          ST_HOLD, ST_STEP: begin
            if (tick) begin
              // A masked output keeps its reset latched so clearing the mask
              // later does not release it outside a release point
              rst_q <= (rst_q & ~rel_mask) | (hold_mask & rel_mask);
              idx   <= idx + 1'b1;
              if (is_last) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= ST_STEP;
              end
            end
          end
          ST_PULSE: begin
            if (tick) begin
              rst_q <= (rst_q & ~pulse_set) | (hold_mask & pulse_set);
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign rst_out = rst_q | hold_mask;

  always_comb begin
    csr_do = '0;
    if (ctrl_sel) begin
      csr_do[NUM_OUTS-1:0] = rst_out;
    end else if (status_sel) begin
      csr_do = status_byte(busy, state, idx);
    end
  end

  assign unused_csr_di = ^csr_di;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboarded bench for reset_sequencer: directed sequences push expected
// rst_out changes and done pulses (value + cycle); a monitor pops on each event.
module tb_reset_sequencer;
  import reset_sequencer_pkg::*;

  localparam int         N    = 6;
  localparam int         H    = 2;
  localparam int         S    = 1;
  localparam logic [4:0] BASE = 5'h0;

  logic         clk = 1'b0;
  logic         rst;
  logic         ce;
  logic         start;
  logic [N-1:0] hold_mask;
  logic [4:0]   csr_a;
  logic [7:0]   csr_di;
  logic         csr_we;
  logic [7:0]   csr_do;
  logic [N-1:0] rst_out;
  logic         busy;
  logic         done;

  logic         ce2;
  logic         start2;
  logic [N-1:0] hold_mask2;
  logic         csr_we2;
  logic [7:0]   csr_do2;
  logic [N-1:0] rst_out2;
  logic         busy2;
  logic         done2;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [N-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           exp_done_q[$];
  logic [N-1:0] model_out;
  logic [N-1:0] prev_out;
  logic         mon_en = 1'b0;

  reset_sequencer #(
    .BASE_ADDR(BASE), .NUM_OUTS(N), .HOLD_TICKS(8'(H)), .STEP_TICKS(8'(S))
  ) u_dut (
    .clk(clk), .rst(rst), .ce(ce), .start(start), .hold_mask(hold_mask),
    .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we), .csr_do(csr_do),
    .rst_out(rst_out), .busy(busy), .done(done)
  );

  reset_sequencer #(
    .BASE_ADDR(5'h4), .NUM_OUTS(N), .HOLD_TICKS(8'd1), .STEP_TICKS(8'd0)
  ) u_dut_slow (
    .clk(clk), .rst(rst), .ce(ce2), .start(start2), .hold_mask(hold_mask2),
    .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we2), .csr_do(csr_do2),
    .rst_out(rst_out2), .busy(busy2), .done(done2)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) ce2 = (cyc % 4 == 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [N-1:0] v, input int c);
    if (v != model_out) begin
      exp_q.push_back(v);
      exp_cyc_q.push_back(c);
    end
    model_out = v;
  endtask

  // Full sequence with HOLD=2, STEP=1: release k lands on edge s+3+2k
  task automatic run_seq(input logic [N-1:0] mask, output int s);
    logic [N-1:0] all1;
    all1 = '1;
    step();
    start = 1'b1;
    s = cyc + 1;
    expect_out('1, s);
    for (int k = 0; k < N; k++) begin
      expect_out((all1 << (k + 1)) | mask, s + (H + 1) + (S + 1) * k);
    end
    exp_done_q.push_back(s + (H + 1) + (S + 1) * (N - 1));
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    check(name, busy, 0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_out !== prev_out) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL rst_out_event: got 0x%0h at cycle %0d, expected no change", rst_out, cyc);
        end else begin
          logic [N-1:0] ev;
          int           ec;
          ev = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          if (rst_out !== ev || cyc != ec) begin
            fails++;
            $display("FAIL rst_out_event: got 0x%0h at cycle %0d, expected 0x%0h at cycle %0d",
                     rst_out, cyc, ev, ec);
          end
        end
        prev_out = rst_out;
      end
      if (done === 1'b1) begin
        tests++;
        if (exp_done_q.size() == 0) begin
          fails++;
          $display("FAIL done_event: got pulse at cycle %0d, expected none", cyc);
        end else begin
          int dc;
          dc = exp_done_q.pop_front();
          if (cyc != dc) begin
            fails++;
            $display("FAIL done_event: got pulse at cycle %0d, expected cycle %0d", cyc, dc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    int n;
    int n_ce;
    int first;
    int second;
    logic ce_next;
    logic seen_done;

    rst = 1'b1; ce = 1'b1; start = 1'b0; hold_mask = '0;
    csr_a = BASE; csr_di = '0; csr_we = 1'b0;
    start2 = 1'b0; hold_mask2 = '0; csr_we2 = 1'b0;
    model_out = '1;
    prev_out  = '1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    check("reset_rst_out", rst_out, 6'h3F);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ctrl_read", csr_do, 8'h3F);
    csr_a = BASE + 5'd1;
    #1 check("reset_status_read", csr_do, 8'h00);
    csr_a = 5'h1F;
    #1 check("unmapped_read", csr_do, 8'h00);
    mon_en = 1'b1;

    // Plain sequence
    run_seq('0, s);
    wait_idle("seq_busy_clear");
    check("seq_final", rst_out, 6'h00);

    // Software pulse of bits 0 and 5
    step();
    csr_a = BASE; csr_di = 8'h21; csr_we = 1'b1;
    n = cyc + 1;
    expect_out(6'h21, n + 1);
    expect_out(6'h00, n + 1 + (H + 1));
    step();
    csr_we = 1'b0;
    step();
    csr_a = BASE + 5'd1;
    #1 check("pulse_status", csr_do & 8'hF0, 8'hB0);
    csr_a = BASE;
    #1 check("pulse_ctrl_read", csr_do, 8'h21);
    wait_idle("pulse_busy_clear");
    check("pulse_final", rst_out, 6'h00);

    // Sequence with bit 2 masked
    step();
    hold_mask = 6'b000100;
    expect_out(6'h04, cyc + 1);
    run_seq(6'b000100, s);
    wait_idle("mask_busy_clear");
    check("mask_final", rst_out, 6'h04);
    step();
    hold_mask = '0;
    repeat (3) step();
    check("mask_clear_holds", rst_out, 6'h04);

    // CTRL write during STEP is deferred until the sequence ends
    run_seq('0, s);
    repeat (7) step();
    csr_a = BASE; csr_di = 8'h02; csr_we = 1'b1;
    expect_out(6'h02, s + 14);
    expect_out(6'h00, s + 17);
    step();
    csr_we = 1'b0;
    check("deferred_no_effect", rst_out, 6'h38);
    repeat (14) step();
    check("deferred_busy_clear", busy, 0);
    check("deferred_final", rst_out, 6'h00);

    // Asynchronous reset mid-STEP, between clock edges
    step();
    start = 1'b1;
    s = cyc + 1;
    expect_out(6'h3F, s);
    expect_out(6'h3E, s + 3);
    expect_out(6'h3C, s + 5);
    step();
    start = 1'b0;
    repeat (6) step();
    csr_a = BASE + 5'd1;
    #2 rst = 1'b1;
    #1;
    check("async_rst_out", rst_out, 6'h3F);
    check("async_busy", busy, 0);
    check("async_status", csr_do, 8'h00);
    expect_out(6'h3F, s + 7);
    step();
    rst = 1'b0;
    repeat (2) step();
    check("after_rst_status", csr_do, 8'h00);
    check("after_rst_out", rst_out, 6'h3F);

    // Sparse ce with HOLD=1, STEP=0 on the second instance
    step();
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    n_ce = 0; first = -1; second = -1; seen_done = 1'b0;
    for (int i = 0; i < 80 && busy2; i++) begin
      ce_next = ce2;
      step();
      if (ce_next) n_ce++;
      if (rst_out2 == 6'h3E && first < 0) first = n_ce;
      if (rst_out2 == 6'h3C && second < 0) second = n_ce;
      if (done2) seen_done = 1'b1;
    end
    check("slow_first_release_ce", first, 2);
    check("slow_second_release_ce", second, 3);
    check("slow_final", rst_out2, 6'h00);
    check("slow_done_seen", seen_done, 1);
    check("slow_busy_clear", busy2, 0);

    repeat (4) step();
    check("exp_q_drained", exp_q.size(), 0);
    check("done_q_drained", exp_done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
